// File: rtl/time_pkg.sv
// Shared types and constants for the time/date/alarm setting controller:
// FSM states, field codes, field limits and bit positions of the packed words.
package time_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_EDIT_T = 2'd1,
      ST_EDIT_A = 2'd2,
      ST_COMMIT = 2'd3
   } state_e;

   localparam int unsigned FIELD_W = 3;
   localparam logic [FIELD_W-1:0] F_HOUR  = 3'd0;
   localparam logic [FIELD_W-1:0] F_MIN   = 3'd1;
   localparam logic [FIELD_W-1:0] F_SEC   = 3'd2;
   localparam logic [FIELD_W-1:0] F_YEAR  = 3'd3;
   localparam logic [FIELD_W-1:0] F_MONTH = 3'd4;
   localparam logic [FIELD_W-1:0] F_DAY   = 3'd5;

   localparam int unsigned VAL_W     = 7;
   localparam int unsigned HOUR_MAX  = 23;
   localparam int unsigned MIN_MAX   = 59;
   localparam int unsigned SEC_MAX   = 59;
   localparam int unsigned YEAR_MAX  = 99;
   localparam int unsigned MONTH_MIN = 1;
   localparam int unsigned MONTH_MAX = 12;
   localparam int unsigned DAY_MIN   = 1;
   localparam int unsigned NOON      = 12;

   // Time word {meridian, hour, min, sec}; the alarm word drops the meridian bit.
   localparam int unsigned TIME_W   = 18;
   localparam int unsigned ALARM_W  = 17;
   localparam int unsigned MER_BIT  = 17;
   localparam int unsigned HOUR_LSB = 12;
   localparam int unsigned HOUR_W   = 5;
   localparam int unsigned MIN_LSB  = 6;
   localparam int unsigned MIN_W    = 6;
   localparam int unsigned SEC_LSB  = 0;
   localparam int unsigned SEC_W    = 6;

   // Date word {year, month, day}.
   localparam int unsigned DATE_W    = 16;
   localparam int unsigned YEAR_LSB  = 9;
   localparam int unsigned YEAR_W    = 7;
   localparam int unsigned MONTH_LSB = 5;
   localparam int unsigned MONTH_W   = 4;
   localparam int unsigned DAY_LSB   = 0;
   localparam int unsigned DAY_W     = 5;

   function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                      input logic [YEAR_W-1:0]  year);
      logic [DAY_W-1:0] d;
      case (month)
         4'd2:                d = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
         default:             d = 5'd31;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/field_step.sv
// Wrapping +1/-1 step of one edit field between inclusive min and max; up wins over down.
module field_step
   import time_pkg::*;
#(
   parameter int unsigned W = VAL_W
) (
   input  logic [W-1:0] val_i,
   input  logic [W-1:0] min_i,
   input  logic [W-1:0] max_i,
   input  logic         up_i,
   input  logic         down_i,
   output logic [W-1:0] next_c_o
);

   always_comb begin
      next_c_o = val_i;
      if (up_i) begin
         next_c_o = (val_i >= max_i) ? min_i : val_i + W'(1);
      end else if (down_i) begin
         next_c_o = (val_i <= min_i) ? max_i : val_i - W'(1);
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time/date/alarm setting FSM with alarm ring control.
// Optional ALARM_SNOOZE_EN: BTN_NEXT while ringing arms a one-shot ring at alarm + 5 min.
module time_set_ctrl
   import time_pkg::*;
#(
   parameter int unsigned RING_SEC = 30,
   parameter int unsigned YEAR_RST = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               BTN_MODE,
   input  logic               BTN_NEXT,
   input  logic               BTN_UP,
   input  logic               BTN_DOWN,
   input  logic               SEC_TICK,
   input  logic [TIME_W-1:0]  CUR_TIME,
   input  logic [DATE_W-1:0]  CUR_DATE,
   output logic               MODE,
   output logic               MODE_STATE,
   output logic               SETTING,
   output logic [TIME_W-1:0]  EDIT_TIME,
   output logic [DATE_W-1:0]  EDIT_DATE,
   output logic [ALARM_W-1:0] ALARM_TIME,
   output logic [FIELD_W-1:0] FIELD_SEL,
   output logic               ALARM_ON,
   output logic               RING
);

   localparam int unsigned RING_W = (RING_SEC < 2) ? 1 : $clog2(RING_SEC + 1);

   state_e               state_q, state_d;
   logic [FIELD_W-1:0]   field_q, field_d;
   logic [TIME_W-1:0]    edit_time_q, edit_time_d;
   logic [DATE_W-1:0]    edit_date_q, edit_date_d;
   logic [ALARM_W-1:0]   alarm_q, alarm_d;
   logic                 alarm_on_q, alarm_on_d;
   logic                 ring_q, ring_d;
   logic [RING_W-1:0]    ring_cnt_q, ring_cnt_d;
   logic                 mode_q, mode_d, mode_state_q, mode_state_d, setting_q, setting_d;
   logic                 match_q;
   logic                 match_c, alarm_hit_c, any_btn_c;
   logic [VAL_W-1:0]     cur_val_c, min_val_c, max_val_c, step_val_c;
   logic [DAY_W-1:0]     dim_cur_c, dim_new_c;

`ifdef ALARM_SNOOZE_EN
   logic                 snz_on_q, snz_on_d, snz_match_q;
   logic [ALARM_W-1:0]   snz_time_q, snz_time_d;
   logic                 snz_match_c, snz_hit_c;

   function automatic logic [ALARM_W-1:0] plus_five(input logic [ALARM_W-1:0] t);
      logic [HOUR_W-1:0] h;
      logic [MIN_W-1:0]  m;
      h = t[HOUR_LSB +: HOUR_W];
      m = t[MIN_LSB +: MIN_W];
      if (m >= MIN_W'(55)) begin
         m = m - MIN_W'(55);
         h = (h == HOUR_W'(HOUR_MAX)) ? '0 : h + HOUR_W'(1);
      end else begin
         m = m + MIN_W'(5);
      end
      return {h, m, t[SEC_LSB +: SEC_W]};
   endfunction

   assign snz_match_c = (CUR_TIME[ALARM_W-1:0] == snz_time_q);
   assign snz_hit_c   = (state_q == ST_RUN) && alarm_on_q && snz_on_q && snz_match_c && !snz_match_q;
`endif

   assign any_btn_c   = BTN_MODE | BTN_NEXT | BTN_UP | BTN_DOWN;
   assign match_c     = (CUR_TIME[ALARM_W-1:0] == alarm_q);
   assign alarm_hit_c = (state_q == ST_RUN) && alarm_on_q && match_c && !match_q;
   assign dim_cur_c   = days_in_month(edit_date_q[MONTH_LSB +: MONTH_W], edit_date_q[YEAR_LSB +: YEAR_W]);

   // Present the selected field and its limits to the shared stepper.
   always_comb begin
      cur_val_c = '0;
      min_val_c = '0;
      max_val_c = VAL_W'(SEC_MAX);
      if (state_q == ST_EDIT_A) begin
         case (field_q)
            F_HOUR:  begin cur_val_c = VAL_W'(alarm_q[HOUR_LSB +: HOUR_W]); max_val_c = VAL_W'(HOUR_MAX); end
            F_MIN:   begin cur_val_c = VAL_W'(alarm_q[MIN_LSB +: MIN_W]);   max_val_c = VAL_W'(MIN_MAX);  end
            default: cur_val_c = VAL_W'(alarm_q[SEC_LSB +: SEC_W]);
         endcase
      end else begin
         case (field_q)
            F_HOUR:  begin cur_val_c = VAL_W'(edit_time_q[HOUR_LSB +: HOUR_W]); max_val_c = VAL_W'(HOUR_MAX); end
            F_MIN:   begin cur_val_c = VAL_W'(edit_time_q[MIN_LSB +: MIN_W]);   max_val_c = VAL_W'(MIN_MAX);  end
            F_SEC:   cur_val_c = VAL_W'(edit_time_q[SEC_LSB +: SEC_W]);
            F_YEAR:  begin cur_val_c = VAL_W'(edit_date_q[YEAR_LSB +: YEAR_W]); max_val_c = VAL_W'(YEAR_MAX); end
            F_MONTH: begin
               cur_val_c = VAL_W'(edit_date_q[MONTH_LSB +: MONTH_W]);
               min_val_c = VAL_W'(MONTH_MIN);
               max_val_c = VAL_W'(MONTH_MAX);
            end
            default: begin
               cur_val_c = VAL_W'(edit_date_q[DAY_LSB +: DAY_W]);
               min_val_c = VAL_W'(DAY_MIN);
               max_val_c = VAL_W'(dim_cur_c);
            end
         endcase
      end
   end

   field_step #(.W(VAL_W)) u_step (
      .val_i    (cur_val_c),
      .min_i    (min_val_c),
      .max_i    (max_val_c),
      .up_i     (BTN_UP),
      .down_i   (BTN_DOWN),
      .next_c_o (step_val_c)
   );

   always_comb begin
      state_d     = state_q;
      field_d     = field_q;
      edit_time_d = edit_time_q;
      edit_date_d = edit_date_q;
      alarm_d     = alarm_q;
      alarm_on_d  = alarm_on_q;
      ring_d      = ring_q;
      ring_cnt_d  = ring_cnt_q;
      dim_new_c   = '0;
`ifdef ALARM_SNOOZE_EN
      snz_on_d    = snz_on_q;
      snz_time_d  = snz_time_q;
`endif

      if (ring_q) begin
         // A press while ringing only silences the alarm.
         if (any_btn_c) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
            if (BTN_NEXT) begin
               snz_on_d   = 1'b1;
               snz_time_d = plus_five(alarm_q);
            end
`endif
         end else if (SEC_TICK) begin
            if (ring_cnt_q <= RING_W'(1)) begin
               ring_d     = 1'b0;
               ring_cnt_d = '0;
            end else begin
               ring_cnt_d = ring_cnt_q - RING_W'(1);
            end
         end
      end else begin
         if (alarm_hit_c) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_W'(RING_SEC);
         end
`ifdef ALARM_SNOOZE_EN
         else if (snz_hit_c) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_W'(RING_SEC);
            snz_on_d   = 1'b0;
         end
`endif
         case (state_q)
            ST_RUN: begin
               if (BTN_MODE) begin
                  edit_time_d = CUR_TIME;
                  edit_date_d = CUR_DATE;
                  field_d     = F_HOUR;
                  state_d     = ST_EDIT_T;
               end else if (!BTN_NEXT && BTN_UP) begin
                  alarm_on_d = !alarm_on_q;
               end
            end
            ST_EDIT_T: begin
               if (BTN_MODE) begin
                  field_d = F_HOUR;
                  state_d = ST_EDIT_A;
               end else if (BTN_NEXT) begin
                  if (field_q == F_DAY) state_d = ST_COMMIT;
                  else                  field_d = field_q + FIELD_W'(1);
               end else if (BTN_UP || BTN_DOWN) begin
                  case (field_q)
                     F_HOUR:  edit_time_d[HOUR_LSB +: HOUR_W]   = HOUR_W'(step_val_c);
                     F_MIN:   edit_time_d[MIN_LSB +: MIN_W]     = MIN_W'(step_val_c);
                     F_SEC:   edit_time_d[SEC_LSB +: SEC_W]     = SEC_W'(step_val_c);
                     F_YEAR:  edit_date_d[YEAR_LSB +: YEAR_W]   = YEAR_W'(step_val_c);
                     F_MONTH: edit_date_d[MONTH_LSB +: MONTH_W] = MONTH_W'(step_val_c);
                     default: edit_date_d[DAY_LSB +: DAY_W]     = DAY_W'(step_val_c);
                  endcase
               end
            end
            ST_EDIT_A: begin
               if (BTN_MODE || (BTN_NEXT && field_q == F_SEC)) begin
                  state_d = ST_RUN;
               end else if (BTN_NEXT) begin
                  field_d = field_q + FIELD_W'(1);
               end else if (BTN_UP || BTN_DOWN) begin
                  case (field_q)
                     F_HOUR:  alarm_d[HOUR_LSB +: HOUR_W] = HOUR_W'(step_val_c);
                     F_MIN:   alarm_d[MIN_LSB +: MIN_W]   = MIN_W'(step_val_c);
                     default: alarm_d[SEC_LSB +: SEC_W]   = SEC_W'(step_val_c);
                  endcase
               end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
         endcase
      end

      if (state_d != ST_RUN) ring_d = 1'b0;

      // Keep the meridian bit and the day field consistent with whatever was written.
      edit_time_d[MER_BIT] = (edit_time_d[HOUR_LSB +: HOUR_W] >= HOUR_W'(NOON));
      dim_new_c = days_in_month(edit_date_d[MONTH_LSB +: MONTH_W], edit_date_d[YEAR_LSB +: YEAR_W]);
      if (edit_date_d[DAY_LSB +: DAY_W] > dim_new_c) edit_date_d[DAY_LSB +: DAY_W] = dim_new_c;

      mode_d       = (state_d != ST_RUN);
      mode_state_d = (state_d == ST_EDIT_A);
      setting_d    = (state_d == ST_COMMIT);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_RUN;
         field_q      <= F_HOUR;
         edit_time_q  <= '0;
         edit_date_q  <= {YEAR_W'(YEAR_RST), MONTH_W'(1), DAY_W'(1)};
         alarm_q      <= '0;
         alarm_on_q   <= 1'b0;
         ring_q       <= 1'b0;
         ring_cnt_q   <= '0;
         match_q      <= 1'b0;
         mode_q       <= 1'b0;
         mode_state_q <= 1'b0;
         setting_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         field_q      <= field_d;
         edit_time_q  <= edit_time_d;
         edit_date_q  <= edit_date_d;
         alarm_q      <= alarm_d;
         alarm_on_q   <= alarm_on_d;
         ring_q       <= ring_d;
         ring_cnt_q   <= ring_cnt_d;
         match_q      <= match_c;
         mode_q       <= mode_d;
         mode_state_q <= mode_state_d;
         setting_q    <= setting_d;
      end
   end

`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         snz_on_q    <= 1'b0;
         snz_time_q  <= '0;
         snz_match_q <= 1'b0;
      end else begin
         snz_on_q    <= snz_on_d;
         snz_time_q  <= snz_time_d;
         snz_match_q <= snz_match_c;
      end
   end
`endif

   assign MODE       = mode_q;
   assign MODE_STATE = mode_state_q;
   assign SETTING    = setting_q;
   assign EDIT_TIME  = edit_time_q;
   assign EDIT_DATE  = edit_date_q;
   assign ALARM_TIME = alarm_q;
   assign FIELD_SEL  = field_q;
   assign ALARM_ON   = alarm_on_q;
   assign RING       = ring_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: stimulus queues expected outputs, a monitor compares after each clock.
module tb_time_set_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        BTN_MODE = 1'b0, BTN_NEXT = 1'b0, BTN_UP = 1'b0, BTN_DOWN = 1'b0;
   logic        SEC_TICK = 1'b0;
   logic [17:0] CUR_TIME = '0;
   logic [15:0] CUR_DATE = '0;
   logic        MODE, MODE_STATE, SETTING, ALARM_ON, RING;
   logic [17:0] EDIT_TIME;
   logic [15:0] EDIT_DATE;
   logic [16:0] ALARM_TIME;
   logic [2:0]  FIELD_SEL;

   always #5 CLK = ~CLK;

   time_set_ctrl #(.RING_SEC(30), .YEAR_RST(16)) dut (
      .CLK(CLK), .RESET(RESET),
      .BTN_MODE(BTN_MODE), .BTN_NEXT(BTN_NEXT), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
      .SEC_TICK(SEC_TICK), .CUR_TIME(CUR_TIME), .CUR_DATE(CUR_DATE),
      .MODE(MODE), .MODE_STATE(MODE_STATE), .SETTING(SETTING),
      .EDIT_TIME(EDIT_TIME), .EDIT_DATE(EDIT_DATE), .ALARM_TIME(ALARM_TIME),
      .FIELD_SEL(FIELD_SEL), .ALARM_ON(ALARM_ON), .RING(RING)
   );

   typedef enum int {K_MODE, K_MSTATE, K_SETTING, K_FIELD, K_ALON, K_RING,
                     K_ETIME, K_EDATE, K_ATIME, K_HOUR, K_MIN, K_MER} kind_e;
   typedef struct {
      int unsigned tgt;
      kind_e       kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   localparam logic [3:0] B_NONE = 4'd0, B_DOWN = 4'd1, B_UP = 4'd2, B_NEXT = 4'd4, B_MODE = 4'd8;

   exp_t        sbq[$];
   int unsigned sample_n = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic [31:0] tm(input logic mer, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      return 32'({mer, h, m, s});
   endfunction

   function automatic logic [31:0] dt(input logic [6:0] y, input logic [3:0] mo, input logic [4:0] d);
      return 32'({y, mo, d});
   endfunction

   function automatic logic [31:0] probe(input kind_e k);
      case (k)
         K_MODE:    return 32'(MODE);
         K_MSTATE:  return 32'(MODE_STATE);
         K_SETTING: return 32'(SETTING);
         K_FIELD:   return 32'(FIELD_SEL);
         K_ALON:    return 32'(ALARM_ON);
         K_RING:    return 32'(RING);
         K_ETIME:   return 32'(EDIT_TIME);
         K_EDATE:   return 32'(EDIT_DATE);
         K_ATIME:   return 32'(ALARM_TIME);
         K_HOUR:    return 32'(EDIT_TIME[16:12]);
         K_MIN:     return 32'(EDIT_TIME[11:6]);
         default:   return 32'(EDIT_TIME[17]);
      endcase
   endfunction

   // Queue an expectation for the outputs seen after the coming clock edge.
   task automatic chk(input kind_e k, input logic [31:0] v, input string nm);
      exp_t e;
      e.tgt  = sample_n + 1;
      e.kind = k;
      e.exp  = v;
      e.name = nm;
      sbq.push_back(e);
   endtask

   task automatic step(input logic [3:0] b, input logic tick);
      {BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN} = b;
      SEC_TICK = tick;
      @(negedge CLK);
      {BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN} = B_NONE;
      SEC_TICK = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         sample_n++;
         while (sbq.size() != 0 && sbq[0].tgt <= sample_n) begin
            exp_t        e;
            logic [31:0] act;
            e   = sbq.pop_front();
            act = probe(e.kind);
            n_checks++;
            if (act !== e.exp) begin
               n_errors++;
               $display("FAIL %s: got 0x%0h, want 0x%0h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge CLK);
      CUR_TIME = 18'(tm(1'b1, 5'd13, 6'd5, 6'd0));
      CUR_DATE = 16'(dt(7'd16, 4'd1, 5'd31));
      chk(K_MODE, 0, "rst_mode");       chk(K_MSTATE, 0, "rst_mode_state");
      chk(K_SETTING, 0, "rst_setting"); chk(K_FIELD, 0, "rst_field");
      chk(K_ETIME, 0, "rst_edit_time"); chk(K_EDATE, dt(7'd16, 4'd1, 5'd1), "rst_edit_date");
      chk(K_ATIME, 0, "rst_alarm_time"); chk(K_ALON, 0, "rst_alarm_on"); chk(K_RING, 0, "rst_ring");
      step(B_NONE, 1'b0);
      RESET = 1'b0;

      // MODE and UP together in RUN: edit entered, alarm enable untouched.
      chk(K_MODE, 1, "enter_mode"); chk(K_MSTATE, 0, "enter_mode_state"); chk(K_FIELD, 0, "enter_field");
      chk(K_ETIME, tm(1'b1, 5'd13, 6'd5, 6'd0), "enter_time"); chk(K_HOUR, 13, "enter_hour");
      chk(K_MER, 1, "enter_meridian"); chk(K_EDATE, dt(7'd16, 4'd1, 5'd31), "enter_date");
      chk(K_ALON, 0, "prio_mode_over_up");
      step(B_MODE | B_UP, 1'b0);

      repeat (9) step(B_UP, 1'b0);
      chk(K_HOUR, 23, "hour_up_23"); chk(K_MER, 1, "meridian_23");
      step(B_UP, 1'b0);
      chk(K_HOUR, 0, "hour_wrap_up"); chk(K_MER, 0, "meridian_midnight");
      step(B_UP, 1'b0);
      chk(K_FIELD, 1, "field_min");
      step(B_NEXT, 1'b0);
      repeat (4) step(B_DOWN, 1'b0);
      chk(K_MIN, 0, "min_down_0");
      step(B_DOWN, 1'b0);
      chk(K_MIN, 59, "min_wrap_down");
      step(B_DOWN, 1'b0);
      repeat (2) step(B_NEXT, 1'b0);
      chk(K_FIELD, 4, "field_month");
      step(B_NEXT, 1'b0);
      chk(K_EDATE, dt(7'd16, 4'd2, 5'd29), "month_clamp_leap");
      step(B_UP, 1'b0);

      // Abort into alarm edit without a commit.
      chk(K_MODE, 1, "abort_mode"); chk(K_MSTATE, 1, "abort_mode_state");
      chk(K_SETTING, 0, "abort_no_setting"); chk(K_FIELD, 0, "abort_field");
      step(B_MODE, 1'b0);
      chk(K_SETTING, 0, "abort_no_setting_late"); chk(K_ATIME, tm(1'b0, 5'd23, 6'd0, 6'd0), "alarm_hour_wrap");
      step(B_DOWN, 1'b0);
      repeat (7) step(B_UP, 1'b0);
      chk(K_ATIME, tm(1'b0, 5'd7, 6'd0, 6'd0), "alarm_0700");
      step(B_UP, 1'b0);
      repeat (2) step(B_NEXT, 1'b0);
      chk(K_MODE, 0, "alarm_exit_mode"); chk(K_MSTATE, 0, "alarm_exit_mode_state");
      step(B_NEXT, 1'b0);

      // Second edit pass ending in a commit after six NEXT presses.
      CUR_TIME = 18'(tm(1'b0, 5'd6, 6'd59, 6'd58));
      CUR_DATE = 16'(dt(7'd16, 4'd2, 5'd29));
      chk(K_EDATE, dt(7'd16, 4'd2, 5'd29), "enter2_date"); chk(K_ETIME, tm(1'b0, 5'd6, 6'd59, 6'd58), "enter2_time");
      step(B_MODE, 1'b0);
      chk(K_FIELD, 1, "prio_next_over_up"); chk(K_ETIME, tm(1'b0, 5'd6, 6'd59, 6'd58), "prio_up_ignored");
      step(B_NEXT | B_UP, 1'b0);
      repeat (2) step(B_NEXT, 1'b0);
      chk(K_EDATE, dt(7'd17, 4'd2, 5'd28), "year_clamp");
      step(B_UP, 1'b0);
      repeat (2) step(B_NEXT, 1'b0);
      chk(K_SETTING, 1, "commit_setting"); chk(K_MODE, 1, "commit_mode"); chk(K_MSTATE, 0, "commit_mode_state");
      step(B_NEXT, 1'b0);
      chk(K_SETTING, 0, "commit_one_cycle"); chk(K_MODE, 0, "commit_to_run");
      step(B_NONE, 1'b0);

      // Alarm ring, timeout after 30 ticks, and early clear by a press.
      chk(K_ALON, 1, "alarm_on_toggle");
      step(B_UP, 1'b0);
      CUR_TIME = 18'(tm(1'b0, 5'd7, 6'd0, 6'd0));
      chk(K_RING, 1, "ring_start");
      step(B_NONE, 1'b0);
      repeat (28) begin
         step(B_NONE, 1'b1);
         step(B_NONE, 1'b0);
      end
      chk(K_RING, 1, "ring_tick29");
      step(B_NONE, 1'b1);
      chk(K_RING, 0, "ring_tick30");
      step(B_NONE, 1'b1);
      repeat (3) step(B_NONE, 1'b0);
      chk(K_RING, 0, "no_retrigger");
      step(B_NONE, 1'b0);
      CUR_TIME = 18'(tm(1'b0, 5'd7, 6'd0, 6'd1));
      step(B_NONE, 1'b0);
      CUR_TIME = 18'(tm(1'b0, 5'd7, 6'd0, 6'd0));
      chk(K_RING, 1, "ring_again");
      step(B_NONE, 1'b0);
      repeat (9) step(B_NONE, 1'b1);
      chk(K_RING, 0, "press_clears_ring"); chk(K_ALON, 1, "press_consumed");
      step(B_UP, 1'b1);
      chk(K_MODE, 0, "still_run"); chk(K_RING, 0, "ring_stays_clear");
      step(B_NONE, 1'b0);

      // Reset in the middle of an edit.
      chk(K_MODE, 1, "edit_before_reset");
      step(B_MODE, 1'b0);
      RESET = 1'b1;
      chk(K_MODE, 0, "rst2_mode"); chk(K_SETTING, 0, "rst2_setting"); chk(K_FIELD, 0, "rst2_field");
      chk(K_ETIME, 0, "rst2_edit_time"); chk(K_EDATE, dt(7'd16, 4'd1, 5'd1), "rst2_edit_date");
      chk(K_ATIME, 0, "rst2_alarm_time"); chk(K_ALON, 0, "rst2_alarm_on");
      step(B_NONE, 1'b0);
      RESET = 1'b0;
      step(B_NONE, 1'b0);
      step(B_NONE, 1'b0);

      if (sbq.size() != 0) begin
         n_errors += sbq.size();
         $display("FAIL drain: %0d expectations pending, want 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The module SHALL have parameter RING_SEC, default 30, alarm ring duration in SEC_TICK pulses.
REQ-002 The module SHALL have parameter YEAR_RST, default 16, EDIT_DATE year value after reset.
REQ-003 The module SHALL have ports: CLK in 1, single clock; RESET in 1, synchronous, active-high.
REQ-004 The module SHALL have inputs BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN, 1 bit each: debounced presses, one cycle wide.
REQ-005 The module SHALL have input SEC_TICK, 1 bit: one-cycle strobe per second from the time counter.
REQ-006 The module SHALL have input CUR_TIME, 18 bits: {meridian[17], hour[16:12], min[11:6], sec[5:0]}.
REQ-007 The module SHALL have input CUR_DATE, 16 bits: {year[15:9], month[8:5], day[4:0]}.
REQ-008 The module SHALL have outputs MODE and MODE_STATE (1 bit each) and SETTING (1 bit), which drive the time counter.
REQ-009 The module SHALL have outputs EDIT_TIME (18 bits), EDIT_DATE (16 bits) and ALARM_TIME (17 bits).
REQ-010 The module SHALL have outputs FIELD_SEL (3 bits, the field being edited), ALARM_ON (1 bit) and RING (1 bit).

Function
REQ-011 All outputs SHALL be registered; a button accepted in cycle n SHALL take effect in cycle n+1.
REQ-012 Simultaneous buttons SHALL follow priority BTN_MODE > BTN_NEXT > BTN_UP > BTN_DOWN; lower-priority presses in the same cycle SHALL be ignored.
REQ-013 The FSM SHALL have states RUN, EDIT_T, EDIT_A and COMMIT.
REQ-014 In RUN: MODE=0, MODE_STATE=0. BTN_UP toggles ALARM_ON. BTN_MODE copies CUR_TIME and CUR_DATE into EDIT_TIME and EDIT_DATE, sets FIELD_SEL=0 and moves to EDIT_T.
REQ-015 In EDIT_T: MODE=1, MODE_STATE=0. Fields: 0 hour (0..23), 1 min (0..59), 2 sec (0..59), 3 year (0..99), 4 month (1..12), 5 day (1..days-in-month).
REQ-016 In EDIT_T and EDIT_A, BTN_UP/BTN_DOWN SHALL step the selected field by +1/-1, wrapping max to min and min to max.
REQ-017 EDIT_TIME[17] SHALL equal (hour >= 12) at all times.
REQ-018 Days-in-month SHALL be 31/30/28, with 29 for February when year%4==0; a month or year change SHALL clamp day down to the new maximum.
REQ-019 In EDIT_T, BTN_NEXT SHALL advance FIELD_SEL; BTN_NEXT on field 5 SHALL go to COMMIT.
REQ-020 In EDIT_T, BTN_MODE SHALL discard edits, set FIELD_SEL=0 and go to EDIT_A, with no SETTING pulse.
REQ-021 COMMIT SHALL last exactly one cycle with SETTING=1 and MODE=1, then go to RUN; SETTING SHALL be 0 in every other state.
REQ-022 In EDIT_A: MODE=1, MODE_STATE=1. Fields 0..2 (hour/min/sec) are edited directly in ALARM_TIME.
REQ-023 In EDIT_A, BTN_NEXT on field 2 or BTN_MODE SHALL return to RUN.
REQ-024 Alarm match is a rising edge of (CUR_TIME[16:0]==ALARM_TIME) while in RUN with ALARM_ON=1 and RING=0. On match, RING=1 and the ring counter loads RING_SEC.
REQ-025 While RING=1, each SEC_TICK SHALL decrement the ring counter; RING SHALL clear when the counter reaches 0.
REQ-026 While RING=1, any button press SHALL clear RING and be consumed, with no FSM effect.
REQ-027 Leaving RUN SHALL clear RING.

Reset
REQ-028 RESET SHALL force state RUN, MODE=0, MODE_STATE=0, SETTING=0, FIELD_SEL=0, EDIT_TIME=0, EDIT_DATE={YEAR_RST,1,1}, ALARM_TIME=0, ALARM_ON=0, RING=0 and ring counter=0.
REQ-029 RESET during EDIT_T or COMMIT SHALL discard edits, and SETTING SHALL be 0 in the following cycle.

Configuration
REQ-030 With ALARM_SNOOZE_EN defined, BTN_NEXT during RING SHALL clear RING and arm a snooze match at ALARM_TIME+5 min (minute/hour wrap mod 24h), which rings once. ALARM_TIME itself SHALL be unchanged.
REQ-031 Without ALARM_SNOOZE_EN, BTN_NEXT during RING SHALL behave as any other press (REQ-026), and no snooze logic SHALL exist.

Structure
REQ-032 Shared package time_pkg SHALL hold: the state enum, field codes, field min/max constants, and bit-slice positions of the time/date/alarm words.
REQ-033 Sub-module field_step SHALL implement the wrapping +1/-1 step with min/max inputs; the days-in-month clamp SHALL stay in this module.

Verification
REQ-034 Reset, then BTN_MODE with CUR_TIME=13:05:00 -> next cycle MODE=1, EDIT_TIME hour=13, EDIT_TIME[17]=1, FIELD_SEL=0.
REQ-035 In EDIT_T on hour=23, BTN_UP -> hour=0; on min=0, BTN_DOWN -> min=59.
REQ-036 Date 2016-01-31; set month=2 -> day=29; set year=17 -> day=28.
REQ-037 Six BTN_NEXT presses -> SETTING high exactly one cycle, then RUN; BTN_MODE mid-edit -> EDIT_A with no SETTING.
REQ-038 ALARM_TIME=07:00:00, ALARM_ON=1, CUR_TIME reaches 07:00:00 -> RING=1; after 30 SEC_TICKs, RING=0; a press at tick 10 clears RING early.
REQ-039 BTN_MODE and BTN_UP in the same cycle in RUN -> EDIT_T entered, ALARM_ON unchanged.
